nlprg_chk: RTL

- Receive-side checker for the N-bit full-period nonlinear PRNG stream. It is the sink counterpart of the nlprg generator.
- Samples the generator output word per valid cycle and self-synchronises onto the sequence. It then predicts each next word (flywheel) and flags and counts mismatches.
- Sits at the far end of a link, FIFO or bus under test. Provides lock status and error statistics to the test/status logic.

---
 rtl/nlprg_chk_if.sv | 23 ++
 rtl/nlprg_chk.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/nlprg_chk_if.sv
// Sample/status bundle between a PRNG stream source and the nlprg_chk receive checker.
interface nlprg_chk_if #(
  parameter int unsigned N     = 7,
  parameter int unsigned ERR_W = 16
);
  logic             din_vld;
  logic [N-1:0]     din;
  logic             clr;
  logic             lock;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             wrap;

  modport master (
    output din_vld, din, clr,
    input  lock, err, err_cnt, wrap
  );

  modport slave (
    input  din_vld, din, clr,
    output lock, err, err_cnt, wrap
  );
endinterface

// File: rtl/nlprg_chk.sv
// Receive-side checker for the full-period nonlinear PRNG: hunts for sync, flywheels when locked.
// Optional all-zero wrap pulse is built only when NLPRG_CHK_WRAP_EN is defined.
module nlprg_chk #(
  parameter int unsigned  N        = 7,
  parameter logic [N-1:0] TAPS     = 7'b1000001,
  parameter int unsigned  LOCK_CNT = 4,
  parameter int unsigned  LOSS_CNT = 3,
  parameter int unsigned  ERR_W    = 16
) (
  input logic        ck,
  input logic        rst_n,
  nlprg_chk_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned SW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LockTgt = MW'(LOCK_CNT);
  localparam logic [SW-1:0] LossTgt = SW'(LOSS_CNT);

  // One-hot pair so a corrupted encoding is distinguishable and falls back to hunting.
  localparam logic [1:0] StHunt   = 2'b01;
  localparam logic [1:0] StLocked = 2'b10;

  function automatic logic [N-1:0] nxt(input logic [N-1:0] s);
    logic f;
    f = (^(s & TAPS)) ^ (s[N-2:0] == '0);
    return {s[N-2:0], f};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     exp_q, exp_d;
  logic             have_exp_q, have_exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [SW-1:0]    miss_q, miss_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             hit;

  assign hit = (bus.din == exp_q);

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    have_exp_d = have_exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    lock_d     = lock_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      StHunt: begin
        if (bus.din_vld) begin
          // Resynchronise on every sample; only a run of correct predictions earns lock.
          exp_d      = nxt(bus.din);
          have_exp_d = 1'b1;
          if (have_exp_q && hit) begin
            match_d = match_q + 1'b1;
            if (match_d == LockTgt) begin
              state_d = StLocked;
              lock_d  = 1'b1;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      StLocked: begin
        if (bus.din_vld) begin
          // Flywheel: prediction advances from itself so corrupt words cannot derail it.
          exp_d = nxt(exp_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            miss_d = miss_q + 1'b1;
            if (miss_d == LossTgt) begin
              state_d    = StHunt;
              lock_d     = 1'b0;
              match_d    = '0;
              have_exp_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d    = StHunt;
        lock_d     = 1'b0;
        have_exp_d = 1'b0;
        match_d    = '0;
        miss_d     = '0;
      end
    endcase

    if (bus.clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      exp_q      <= '0;
      have_exp_q <= 1'b0;
      match_q    <= '0;
      miss_q     <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      have_exp_q <= have_exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.lock    = lock_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

`ifdef NLPRG_CHK_WRAP_EN
  logic wrap_q, wrap_d;

  assign wrap_d = bus.din_vld && (state_q == StLocked) && hit && (exp_q == '0);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap = wrap_q;
`else
  assign bus.wrap = 1'b0;
`endif

endmodule
